// File: rtl/ama_riscv_mult_ctrl.sv
// ============================================================================
// ama_riscv_mult_ctrl: multi-cycle sequencer with one-entry result cache
// around the 32x32 MUL/MULH/MULHSU/MULHU datapath.  Rev 1.0
// ============================================================================
`default_nettype none

package ama_riscv_mult_pkg;
  typedef enum logic [1:0] {
    MULT_OP_MUL    = 2'd0,
    MULT_OP_MULH   = 2'd1,
    MULT_OP_MULHSU = 2'd2,
    MULT_OP_MULHU  = 2'd3
  } mult_op_t;
endpackage

module ama_riscv_mult_ctrl
  import ama_riscv_mult_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  mult_op_t    req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        kill,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_p,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 2);

  logic [1:0]  state;
  logic [2:0]  cnt;
  mult_op_t    op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  logic        cache_vld;
  mult_op_t    cache_op;
  logic [31:0] cache_a;
  logic [31:0] cache_b;
  logic [63:0] cache_p;

  logic        accept;
  logic        hit;
  logic [31:0] hit_p;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic [31:0] result;

  always_comb begin
    req_ready = (state == ST_IDLE || (state == ST_RESP && rsp_ready)) && !kill && !rst;
    accept    = req_valid && req_ready;
    // A MUL can reuse any cached product: the low half is signedness-independent.
    hit       = cache_vld && (req_a == cache_a) && (req_b == cache_b) &&
                (req_op == MULT_OP_MUL || req_op == cache_op);
    hit_p     = (req_op == MULT_OP_MUL) ? cache_p[31:0] : cache_p[63:32];
    busy      = (state != ST_IDLE);
  end

  always_comb begin
    ext_a   = (op_q == MULT_OP_MULHU) ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
    ext_b   = (op_q == MULT_OP_MUL || op_q == MULT_OP_MULH) ?
              {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    product = ext_a * ext_b;
    result  = (op_q == MULT_OP_MUL) ? product[31:0] : product[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      op_q      <= MULT_OP_MUL;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_p     <= 32'd0;
      cache_vld <= 1'b0;
      cache_op  <= MULT_OP_MUL;
      cache_a   <= 32'd0;
      cache_b   <= 32'd0;
      cache_p   <= 64'd0;
    end else if (kill) begin
      state     <= ST_IDLE;
      rsp_valid <= 1'b0;
    end else if (accept) begin
      op_q <= req_op;
      a_q  <= req_a;
      b_q  <= req_b;
      if (hit) begin
        state     <= ST_RESP;
        rsp_valid <= 1'b1;
        rsp_p     <= hit_p;
      end else begin
        state     <= ST_CALC;
        cnt       <= CNT_INIT;
        rsp_valid <= 1'b0;
      end
    end else begin
      case (state)
        ST_CALC: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_p     <= result;
            cache_vld <= 1'b1;
            cache_op  <= op_q;
            cache_a   <= a_q;
            cache_b   <= b_q;
            cache_p   <= product;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        ST_IDLE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ama_riscv_mult_ctrl.sv
// Testbench for ama_riscv_mult_ctrl: directed plan items plus randomized ops
// on LATENCY=2 and LATENCY=8 instances, checked against an arithmetic model.
`default_nettype none

module tb_ama_riscv_mult_ctrl;
  import ama_riscv_mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        kill = 1'b0;
  logic        rsp_ready = 1'b0;
  mult_op_t    req_op = MULT_OP_MUL;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  bit          sel = 1'b0;

  logic        rdy0, rdy1, rv0, rv1, busy0, busy1;
  logic [31:0] p0, p1;
  logic        req_ready, rsp_valid, busy;
  logic [31:0] rsp_p;

  assign req_ready = sel ? rdy1  : rdy0;
  assign rsp_valid = sel ? rv1   : rv0;
  assign busy      = sel ? busy1 : busy0;
  assign rsp_p     = sel ? p1    : p0;

  always #5 clk = ~clk;

  ama_riscv_mult_ctrl #(.LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rdy0),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .kill(kill),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_p(p0), .busy(busy0)
  );

  ama_riscv_mult_ctrl #(.LATENCY(8)) u_dut_l8 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rdy1),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .kill(kill),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_p(p1), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;

  // Model of each instance's cache key (the value itself comes from ref_res).
  bit          cvld[2];
  logic [31:0] ca[2];
  logic [31:0] cb[2];
  mult_op_t    cop[2];

  logic [31:0] ra, rb;
  mult_op_t    rop;
  bit          h, b2b, in_resp, seen;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(mult_op_t op, logic [31:0] a, logic [31:0] b);
    int     ia, ib;
    longint x, y, p;
    ia = a;
    ib = b;
    x = (op == MULT_OP_MULHU) ? longint'({32'd0, a}) : longint'(ia);
    y = (op == MULT_OP_MUL || op == MULT_OP_MULH) ? longint'(ib) : longint'({32'd0, b});
    p = x * y;
    return (op == MULT_OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic bit model_hit(mult_op_t op, logic [31:0] a, logic [31:0] b);
    return cvld[sel] && a == ca[sel] && b == cb[sel] &&
           (op == MULT_OP_MUL || op == cop[sel]);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; kill = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_p", rsp_p, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    rst = 1'b0;
    cvld[0] = 1'b0;
    cvld[1] = 1'b0;
    #1 chk("post_rst_ready", req_ready, 1);
    @(negedge clk);
  endtask

  // Present a request at a negedge; returns after the accepting posedge.
  task automatic start(mult_op_t op, logic [31:0] a, logic [31:0] b, output bit hit);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; kill = 1'b0;
    #1 chk("req_ready", req_ready, 1);
    hit = model_hit(op, a, b);
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic wait_rsp(mult_op_t op, logic [31:0] a, logic [31:0] b, bit hit);
    int n;
    int exp_lat;
    n = 1;
    exp_lat = hit ? 1 : (sel ? 8 : 2);
    if (!hit) begin
      chk("calc_ready", req_ready, 0);
      chk("calc_valid", rsp_valid, 0);
    end
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, exp_lat);
    chk("rsp_p", rsp_p, ref_res(op, a, b));
    if (!hit) begin
      cvld[sel] = 1'b1; ca[sel] = a; cb[sel] = b; cop[sel] = op;
    end
  endtask

  task automatic op_full(mult_op_t op, logic [31:0] a, logic [31:0] b);
    bit hh;
    start(op, a, b, hh);
    wait_rsp(op, a, b, hh);
  endtask

  task automatic hold(int k);
    logic [31:0] p;
    p = rsp_p;
    repeat (k) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_p", rsp_p, p);
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("drain_valid", rsp_valid, 0);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Plain miss, cache hit, op-mismatch miss, signedness
    op_full(MULT_OP_MUL, 32'd7, 32'hFFFF_FFFD);
    chk("spec_mul_neg", rsp_p, 32'hFFFF_FFEB);
    consume();
    op_full(MULT_OP_MULH, 32'h8000_0000, 32'h8000_0000);
    chk("spec_mulh_min", rsp_p, 32'h4000_0000);
    consume();
    start(MULT_OP_MUL, 32'h8000_0000, 32'h8000_0000, h);
    chk("spec_hit_expected", h, 1);
    wait_rsp(MULT_OP_MUL, 32'h8000_0000, 32'h8000_0000, h);
    consume();
    op_full(MULT_OP_MULHU, 32'h8000_0000, 32'h8000_0000);
    chk("spec_mulhu_min", rsp_p, 32'h4000_0000);
    consume();
    op_full(MULT_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("spec_mulhu_ones", rsp_p, 32'hFFFF_FFFE);
    consume();
    op_full(MULT_OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("spec_mulh_ones", rsp_p, 32'h0000_0000);
    consume();
    op_full(MULT_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("spec_mulhsu_ones", rsp_p, 32'hFFFF_FFFF);

    // Backpressure then back-to-back with no idle bubble
    hold(3);
    rsp_ready = 1'b1;
    start(MULT_OP_MUL, 32'd9, 32'd9, h);
    chk("b2b_no_bubble", busy, 1);
    wait_rsp(MULT_OP_MUL, 32'd9, 32'd9, h);
    consume();

    // Kill in CALC, then repeat misses
    do_reset();
    start(MULT_OP_MUL, 32'd5, 32'd6, h);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_calc_busy", busy, 0);
    chk("kill_calc_valid", rsp_valid, 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("kill_no_rsp", seen, 0);
    op_full(MULT_OP_MUL, 32'd5, 32'd6);
    chk("spec_kill_repeat", rsp_p, 32'd30);

    // Kill in RESP keeps the cache
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_resp_valid", rsp_valid, 0);
    start(MULT_OP_MUL, 32'd5, 32'd6, h);
    chk("kill_resp_cache_hit", h, 1);
    wait_rsp(MULT_OP_MUL, 32'd5, 32'd6, h);
    consume();

    // Kill together with a request in IDLE
    req_valid = 1'b1; req_op = MULT_OP_MUL; req_a = 32'd3; req_b = 32'd3; kill = 1'b1;
    #1 chk("kill_idle_ready", req_ready, 0);
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0;
    chk("kill_idle_busy", busy, 0);

    // Reset in RESP invalidates the cache
    op_full(MULT_OP_MULHU, 32'd123, 32'd456);
    do_reset();
    op_full(MULT_OP_MULHU, 32'd123, 32'd456);
    consume();

    // LATENCY=8 instance
    sel = 1'b1;
    op_full(MULT_OP_MUL, 32'd7, 32'hFFFF_FFFD);
    chk("spec_l8_val", rsp_p, 32'hFFFF_FFEB);
    consume();

    // Randomized traffic on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      in_resp = 1'b0;
      ra = pick();
      rb = pick();
      for (int i = 0; i < 30; i++) begin
        rop = mult_op_t'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) begin
          ra = pick();
          rb = pick();
        end
        b2b = 1'b0;
        if (in_resp) begin
          if ($urandom_range(0, 2) == 0) consume();
          else begin
            b2b = 1'b1;
            rsp_ready = 1'b1;
          end
        end
        start(rop, ra, rb, h);
        if (b2b) chk("rand_no_bubble", busy, 1);
        wait_rsp(rop, ra, rb, h);
        hold($urandom_range(0, 3));
        in_resp = 1'b1;
      end
      consume();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
